// File: rtl/rs_load_queue.sv
// Load reservation station. Holds in-flight loads, wakes them from the CDB and
// issues ready loads oldest-first through a registered memory request slot.
module rs_load_queue #(
  parameter int ENTRIES  = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [15:0]                  dispatch_instr,
  input  logic [TAG_W-1:0]             base_tag,
  input  logic [DATA_W-1:0]            base_value,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         rs_update_en,
  output logic [2:0]                   rs_update_reg,
  output logic [TAG_W-1:0]             rs_update_tag,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [DATA_W-1:0]            mem_req_addr,
  output logic [2:0]                   mem_req_rd,
  output logic [TAG_W-1:0]             mem_req_tag,
  input  logic                         flush,
  output logic [$clog2(ENTRIES+1)-1:0] busy_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES+1);
  localparam logic [TAG_W-1:0] TAG0 = TAG_W'(TAG_BASE);

  logic [ENTRIES-1:0] busy_q;
  logic [TAG_W-1:0]   qj_q  [ENTRIES];
  logic [DATA_W-1:0]  vj_q  [ENTRIES];
  logic [3:0]         off_q [ENTRIES];
  logic [2:0]         rd_q  [ENTRIES];
  logic [IDX_W-1:0]   age_q [ENTRIES];

  logic [2:0]        ds_rs, ds_rd;
  logic [3:0]        ds_off;
  logic              accept;
  logic [IDX_W-1:0]  free_idx;
  logic [TAG_W-1:0]  cap_qj;
  logic [DATA_W-1:0] cap_vj;
  logic              iss_found, slot_load, issue;
  logic [IDX_W-1:0]  iss_idx, iss_age;
  logic [DATA_W-1:0] iss_addr;
  logic              instr_unused;

  assign ds_rs  = dispatch_instr[9:7];
  assign ds_rd  = dispatch_instr[6:4];
  assign ds_off = dispatch_instr[3:0];
  assign instr_unused = ^dispatch_instr[15:10];

  assign dispatch_ready = ~&busy_q;
  assign accept         = dispatch_valid && dispatch_ready;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!busy_q[i]) free_idx = IDX_W'(i);
  end

  // Base operand: register file, then same-cycle CDB bypass, else wait on the tag
  always_comb begin
    cap_qj = '0;
    cap_vj = '0;
    if (ds_rs != 3'd0) begin
      if (base_tag == '0)
        cap_vj = base_value;
      else if (cdb_valid && cdb_tag == base_tag)
        cap_vj = cdb_data;
      else
        cap_qj = base_tag;
    end
  end

  always_comb begin
    iss_found = 1'b0;
    iss_idx   = '0;
    iss_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && qj_q[i] == '0 && (!iss_found || age_q[i] > iss_age)) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
        iss_age   = age_q[i];
      end
    end
  end

  assign slot_load = !mem_req_valid || mem_req_ready;
  assign issue     = slot_load && iss_found;
  assign iss_addr  = vj_q[iss_idx] + {{(DATA_W-4){off_q[iss_idx][3]}}, off_q[iss_idx]};

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      busy_q        <= '0;
      busy_count    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_rd    <= '0;
      mem_req_tag   <= '0;
      rs_update_en  <= 1'b0;
      rs_update_reg <= '0;
      rs_update_tag <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[i] && cdb_valid && cdb_tag != '0 && qj_q[i] == cdb_tag) begin
          qj_q[i] <= '0;
          vj_q[i] <= cdb_data;
        end
        // Age counts busy younger entries, so it stays below ENTRIES
        if (busy_q[i]) begin
          if (accept && !(issue && age_q[i] > iss_age))
            age_q[i] <= age_q[i] + 1'b1;
          else if (!accept && issue && age_q[i] > iss_age)
            age_q[i] <= age_q[i] - 1'b1;
        end
      end

      if (issue)
        busy_q[iss_idx] <= 1'b0;

      if (accept) begin
        busy_q[free_idx] <= 1'b1;
        qj_q[free_idx]   <= cap_qj;
        vj_q[free_idx]   <= cap_vj;
        off_q[free_idx]  <= ds_off;
        rd_q[free_idx]   <= ds_rd;
        age_q[free_idx]  <= '0;
      end

      busy_count <= busy_count + CNT_W'(accept) - CNT_W'(issue);

      if (slot_load) begin
        mem_req_valid <= iss_found;
        if (iss_found) begin
          mem_req_addr <= iss_addr;
          mem_req_rd   <= rd_q[iss_idx];
          mem_req_tag  <= TAG0 + TAG_W'(iss_idx);
        end
      end

      rs_update_en  <= accept && ds_rd != 3'd0;
      rs_update_reg <= (accept && ds_rd != 3'd0) ? ds_rd : 3'd0;
      rs_update_tag <= (accept && ds_rd != 3'd0) ? TAG0 + TAG_W'(free_idx) : '0;
    end
  end

endmodule
